// File: rtl/muldiv_pkg.sv
// Shared types and default sizes for the iterative multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULLO = 2'd0,
        OP_MULHI = 2'd1,
        OP_DIVU  = 2'd2,
        OP_REMU  = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH    = 32;
    localparam int DEF_SEL_BITS = 5;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit: one result bit per clock, single op in flight,
// one-cycle write-back pulse to the register file.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int SEL_BITS = DEF_SEL_BITS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [1:0]          op,
    input  logic [WIDTH-1:0]    opa,
    input  logic [WIDTH-1:0]    opb,
    input  logic [SEL_BITS-1:0] dest,
    output logic                busy,
    output logic [WIDTH-1:0]    result,
    output logic [SEL_BITS-1:0] result_sel,
    output logic                result_we
);

    localparam int CNT_BITS = $clog2(WIDTH) + 1;
    localparam logic [CNT_BITS-1:0] LAST = CNT_BITS'(WIDTH);

    state_t              state, state_nxt;
    op_t                 op_q;
    logic [SEL_BITS-1:0] dest_q;
    logic [CNT_BITS-1:0] cnt;
    logic [WIDTH-1:0]    hi, lo, opnd;

    logic                is_div, iter_done;
    logic [WIDTH:0]      shifted, add_a, add_b;
    logic [WIDTH+1:0]    sum;

    // {hi, lo} is the product register for MUL; for DIV hi is the partial remainder
    // and lo shifts the dividend out of its MSB while the quotient enters at its LSB.
    assign is_div    = (op_q == OP_DIVU) || (op_q == OP_REMU);
    assign iter_done = (cnt == LAST);
    assign shifted   = {hi, lo[WIDTH-1]};

    // One shared adder: MUL adds the multiplicand, DIV adds ~divisor + 1.
    assign add_a = is_div ? shifted : {1'b0, hi};
    assign add_b = is_div ? ~{1'b0, opnd} : {1'b0, (lo[0] ? opnd : {WIDTH{1'b0}})};
    assign sum   = {1'b0, add_a} + {1'b0, add_b} + (WIDTH+2)'(is_div);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (iter_done) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: the whole datapath is async-reset so outputs drop to zero the instant reset rises.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q       <= OP_MULLO;
            dest_q     <= '0;
            cnt        <= '0;
            hi         <= '0;
            lo         <= '0;
            opnd       <= '0;
            result     <= '0;
            result_sel <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q   <= op_t'(op);
                        dest_q <= dest;
                        cnt    <= '0;
                        hi     <= '0;
                        lo     <= opa;
                        opnd   <= opb;
                    end
                end
                S_RUN: begin
                    if (!iter_done) begin
                        cnt <= cnt + 1'b1;
                        if (is_div) begin
                            // sum[WIDTH+1] is the no-borrow flag: remainder stayed non-negative.
                            hi <= sum[WIDTH+1] ? sum[WIDTH-1:0] : shifted[WIDTH-1:0];
                            lo <= {lo[WIDTH-2:0], sum[WIDTH+1]};
                        end else begin
                            hi <= sum[WIDTH:1];
                            lo <= {sum[0], lo[WIDTH-1:1]};
                        end
                    end else begin
                        result     <= ((op_q == OP_MULLO) || (op_q == OP_DIVU)) ? lo : hi;
                        result_sel <= dest_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state != S_IDLE);
    assign result_we = (state == S_DONE);

endmodule
